gcd_requester: RTL and testbench
================================

# gcd_requester

Host-side requester for the iterative GCD unit. Accepts operand pairs over a valid/ready request channel and launches the GCD unit with a reset pulse followed by enable. It waits for `done`, then returns the result (or a timeout error) over a valid/ready response channel. It sits between the board-level input logic (switch capture / test sequencer) and the GCD controller+datapath, acting as the initiator to that unit's responder.

## Interface
- `WIDTH`, 4: operand and result width.
- `TIMEOUT`, 64: maximum number of RUN cycles before the job is abandoned (≥2).

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low; reset is synchronous and active-low
- `req_valid`  in  1  request operand pair present
- `req_ready`  out  1  requester can accept a pair
- `req_x`  in  WIDTH  operand x
- `req_y`  in  WIDTH  operand y
- `gcd_x_i`  out  WIDTH  operand x to GCD unit
- `gcd_y_i`  out  WIDTH  operand y to GCD unit
- `gcd_reset`  out  1  active-high reset to GCD unit
- `gcd_enable`  out  1  enable to GCD unit
- `gcd_done`  in  1  GCD unit finished
- `gcd_d_o`  in  WIDTH  GCD unit result
- `rsp_valid`  out  1  result present
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  WIDTH  result value
- `rsp_err`  out  1  1 = timeout, `rsp_data` = 0
- `job_count`  out  8  completed responses, wraps 255→0

## Operation
- States: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`: latch `req_x`/`req_y` into operand registers.
  - If either operand is 0 → RESP with `rsp_data` = x|y (gcd(a,0)=a, gcd(0,0)=0), `rsp_err`=0. No GCD launch; the unit would never terminate on a zero operand.
  - Otherwise → CLEAR.
- CLEAR: one cycle, `gcd_reset`=1, timer cleared → RUN.
- RUN:
  - `gcd_enable`=1, `gcd_reset`=0, timer increments each cycle.
  - `gcd_done`=1 sampled → capture `gcd_d_o` into `rsp_data`, `rsp_err`=0 → RESP.
  - Timer reaches `TIMEOUT`-1 without done → `rsp_data`=0, `rsp_err`=1 → RESP.
  - Done and timeout on the same edge: done wins.
- RESP:
  - `rsp_valid`=1; `rsp_data`/`rsp_err` held stable.
  - On `rsp_ready` → IDLE and `job_count`+1.
- `gcd_reset`=1 in every state except RUN, which keeps the unit parked. `gcd_enable`=1 only in RUN.
- `gcd_x_i`/`gcd_y_i` are driven from the operand registers and are stable from CLEAR through RESP.
- `req_ready`=0 outside IDLE; no request overlap or queuing.

## Timing
- Reset: on any edge with `reset`=0, state→IDLE, operand registers, `rsp_data`, `rsp_err`, timer and `job_count` → 0. Outputs after that edge: `req_ready`=1, `gcd_reset`=1, `gcd_enable`=0, `rsp_valid`=0, `gcd_x_i`=`gcd_y_i`=0.
- Reset mid-job (any state): job discarded, no response, `rsp_valid` low from the next cycle.
- Request accepted at edge N:
  - CLEAR during cycle N..N+1.
  - RUN from edge N+1, so `gcd_enable`=1 in cycle N+1 onward.
- `gcd_done` seen at edge M → `rsp_valid`=1 from edge M; `gcd_enable` drops at the same edge.
- Bypass path: accepted at edge N → `rsp_valid`=1 from edge N.
- Timeout: `rsp_valid` asserts exactly `TIMEOUT` cycles after RUN entry.
- Response accepted at edge K (`rsp_valid`&&`rsp_ready`) → `req_ready`=1 from edge K. Minimum spacing is one IDLE cycle per job.
- `rsp_ready` is ignored outside RESP. `req_valid` is ignored outside IDLE.
- `job_count` increments on response handshake only (errors included) and wraps modulo 256.

## Test plan
- (12,8) with behavioral GCD model → `gcd_reset` 1 cycle then `gcd_enable` until done; `rsp_data`=4, `rsp_err`=0, `job_count`=1. Also (7,7) → 7 and (15,1) → 1.
- (9,0) → `rsp_valid` at the edge after accept, `rsp_data`=9, `rsp_err`=0, `gcd_enable` never 1. (0,0) → `rsp_data`=0.
- GCD model that never raises done → `rsp_valid` exactly 64 cycles after RUN entry, `rsp_data`=0, `rsp_err`=1, `gcd_reset` reasserted. Done on the final timeout cycle → `rsp_err`=0.
- `rsp_ready` held low 5 cycles in RESP → `rsp_valid`/`rsp_data` stable, `req_ready`=0, new `req_valid` not accepted; `rsp_ready` high → IDLE next edge.
- `reset`=0 for one edge in RUN → IDLE, `rsp_valid`=0, `job_count`=0, `gcd_enable`=0. The following (6,4) job → 2.
- 256 back-to-back (3,6) jobs with `rsp_ready`=1 → every `rsp_data`=3, `job_count` wraps to 0.

Source files
------------

// File: rtl/gcd_requester.sv
// ============================================================================
//  Module      : gcd_requester
//  Description : Host-side requester for the iterative GCD unit. Takes an
//                operand pair over a valid/ready request channel, parks and
//                launches the GCD unit, waits for done (bounded by a timeout)
//                and returns the result over a valid/ready response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gcd_requester #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  // GCD unit interface
  output logic [WIDTH-1:0] gcd_x_i,
  output logic [WIDTH-1:0] gcd_y_i,
  output logic             gcd_reset,
  output logic             gcd_enable,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_d_o,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [7:0]       job_count
);

  localparam int c_TIMER_W = $clog2(TIMEOUT);
  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_op_x;
  logic [WIDTH-1:0]     r_op_y;
  logic [WIDTH-1:0]     r_rsp_data;
  logic                 r_rsp_err;
  logic [c_TIMER_W-1:0] r_timer;
  logic [7:0]           r_job_count;
  logic                 r_req_ready;
  logic                 r_gcd_reset;
  logic                 r_gcd_enable;
  logic                 r_rsp_valid;

  // Job sequencer: state, operands, timer, response and all handshake outputs
  // are registered together so every output changes on the same edge as the
  // state it belongs to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_op_x       <= '0;
      r_op_y       <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_timer      <= '0;
      r_job_count  <= 8'd0;
      r_req_ready  <= 1'b1;
      r_gcd_reset  <= 1'b1;
      r_gcd_enable <= 1'b0;
      r_rsp_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone is the handshake
          if (req_valid) begin
            r_op_x      <= req_x;
            r_op_y      <= req_y;
            r_req_ready <= 1'b0;
            if ((req_x == '0) || (req_y == '0)) begin
              // gcd(a,0)=a and gcd(0,0)=0; the unit would never finish on a zero
              r_rsp_data  <= req_x | req_y;
              r_rsp_err   <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else begin
              r_state <= S_CLEAR;
            end
          end
        end

        S_CLEAR: begin
          // unit has seen one reset cycle with the new operands; release it
          r_timer      <= '0;
          r_gcd_reset  <= 1'b0;
          r_gcd_enable <= 1'b1;
          r_state      <= S_RUN;
        end

        S_RUN: begin
          if (gcd_done) begin
            // done takes priority over a coincident timeout
            r_rsp_data   <= gcd_d_o;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b1;
            r_gcd_reset  <= 1'b1;
            r_gcd_enable <= 1'b0;
            r_state      <= S_RESP;
          end else if (r_timer == c_TIMER_LAST) begin
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b1;
            r_rsp_valid  <= 1'b1;
            r_gcd_reset  <= 1'b1;
            r_gcd_enable <= 1'b0;
            r_state      <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_job_count <= r_job_count + 8'd1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state      <= S_IDLE;
          r_req_ready  <= 1'b1;
          r_gcd_reset  <= 1'b1;
          r_gcd_enable <= 1'b0;
          r_rsp_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign gcd_x_i    = r_op_x;
  assign gcd_y_i    = r_op_y;
  assign gcd_reset  = r_gcd_reset;
  assign gcd_enable = r_gcd_enable;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;
  assign job_count  = r_job_count;

endmodule

`default_nettype wire

// File: tb/tb_gcd_requester.sv
// ============================================================================
//  Module      : tb_gcd_requester
//  Description : Directed self-checking bench for gcd_requester with a
//                behavioural GCD unit that can also hang or finish late.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gcd_requester;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_x;
  logic [3:0] req_y;
  logic [3:0] gcd_x_i;
  logic [3:0] gcd_y_i;
  logic       gcd_reset;
  logic       gcd_enable;
  logic       gcd_done;
  logic [3:0] gcd_d_o;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [7:0] job_count;

  int checks   = 0;
  int failures = 0;

  // 0 = normal GCD, 1 = never done, 2 = done exactly on the last timeout cycle
  int mode = 0;

  gcd_requester #(.WIDTH(4), .TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .gcd_x_i    (gcd_x_i),
    .gcd_y_i    (gcd_y_i),
    .gcd_reset  (gcd_reset),
    .gcd_enable (gcd_enable),
    .gcd_done   (gcd_done),
    .gcd_d_o    (gcd_d_o),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .job_count  (job_count)
  );

  always #5 clk = ~clk;

  // behavioural subtractive GCD unit
  logic [3:0] m_a = 4'd0;
  logic [3:0] m_b = 4'd0;
  logic       m_done = 1'b0;
  int         m_cnt = 0;

  always @(posedge clk) begin
    if (gcd_reset) begin
      m_a    <= gcd_x_i;
      m_b    <= gcd_y_i;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (gcd_enable) begin
      m_cnt <= m_cnt + 1;
      if (!m_done) begin
        if (m_a == m_b)     m_done <= 1'b1;
        else if (m_a > m_b) m_a <= m_a - m_b;
        else                m_b <= m_b - m_a;
      end
    end
  end

  always_comb begin
    gcd_done = m_done;
    gcd_d_o  = m_a;
    case (mode)
      1: gcd_done = 1'b0;
      2: begin
        gcd_done = (m_cnt == 63);
        gcd_d_o  = 4'd5;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- helpers
  // all helpers start and end just after a falling edge
  task automatic send_req(input logic [3:0] x, input logic [3:0] y);
    req_valid = 1'b1;
    req_x     = x;
    req_y     = y;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int en, output bit to);
    lat = 0;
    en  = 0;
    to  = 1'b0;
    while (!rsp_valid && lat < 300) begin
      if (gcd_enable) en++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) to = 1'b1;
  endtask

  task automatic ack_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    do_reset();
    checks++;
    if (req_ready !== 1'b1 || gcd_reset !== 1'b1 || gcd_enable !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got rdy=%b grst=%b gen=%b vld=%b, want 1 1 0 0",
               req_ready, gcd_reset, gcd_enable, rsp_valid);
    end
    checks++;
    if (gcd_x_i !== 4'd0 || gcd_y_i !== 4'd0 || job_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_regs: got x=%0d y=%0d cnt=%0d, want 0 0 0", gcd_x_i, gcd_y_i, job_count);
    end
  endtask

  task automatic test_gcd_basic();
    int lat, en;
    bit to;
    send_req(4'd12, 4'd8);
    checks++;
    if (gcd_reset !== 1'b1 || gcd_enable !== 1'b0 || req_ready !== 1'b0 || gcd_x_i !== 4'd12 || gcd_y_i !== 4'd8) begin
      failures++;
      $display("FAIL clear_cycle: got grst=%b gen=%b rdy=%b x=%0d y=%0d, want 1 0 0 12 8",
               gcd_reset, gcd_enable, req_ready, gcd_x_i, gcd_y_i);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (gcd_reset !== 1'b0 || gcd_enable !== 1'b1) begin
      failures++;
      $display("FAIL run_entry: got grst=%b gen=%b, want 0 1", gcd_reset, gcd_enable);
    end
    wait_rsp(lat, en, to);
    checks++;
    if (to || rsp_data !== 4'd4 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL gcd_12_8: got to=%b data=%0d err=%b, want 0 4 0", to, rsp_data, rsp_err);
    end
    checks++;
    if (gcd_reset !== 1'b1 || gcd_enable !== 1'b0) begin
      failures++;
      $display("FAIL resp_park: got grst=%b gen=%b, want 1 0", gcd_reset, gcd_enable);
    end
    ack_rsp();
    checks++;
    if (job_count !== 8'd1 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL after_ack: got cnt=%0d rdy=%b vld=%b, want 1 1 0", job_count, req_ready, rsp_valid);
    end
  endtask

  task automatic test_gcd_more();
    int lat, en;
    bit to;
    logic [3:0] xs [2] = '{4'd7, 4'd15};
    logic [3:0] ys [2] = '{4'd7, 4'd1};
    logic [3:0] es [2] = '{4'd7, 4'd1};
    for (int i = 0; i < 2; i++) begin
      send_req(xs[i], ys[i]);
      wait_rsp(lat, en, to);
      checks++;
      if (to || rsp_data !== es[i] || rsp_err !== 1'b0) begin
        failures++;
        $display("FAIL gcd_vec%0d: got to=%b data=%0d err=%b, want 0 %0d 0", i, to, rsp_data, rsp_err, es[i]);
      end
      ack_rsp();
    end
    checks++;
    if (job_count !== 8'd3) begin
      failures++;
      $display("FAIL count_3: got %0d, want 3", job_count);
    end
  endtask

  task automatic test_bypass();
    int lat, en;
    bit to;
    send_req(4'd9, 4'd0);
    wait_rsp(lat, en, to);
    checks++;
    if (to || lat != 0 || rsp_data !== 4'd9 || rsp_err !== 1'b0 || en != 0) begin
      failures++;
      $display("FAIL bypass_9_0: got to=%b lat=%0d data=%0d err=%b en=%0d, want 0 0 9 0 0",
               to, lat, rsp_data, rsp_err, en);
    end
    ack_rsp();
    send_req(4'd0, 4'd0);
    wait_rsp(lat, en, to);
    checks++;
    if (to || lat != 0 || rsp_data !== 4'd0 || rsp_err !== 1'b0 || en != 0) begin
      failures++;
      $display("FAIL bypass_0_0: got to=%b lat=%0d data=%0d err=%b en=%0d, want 0 0 0 0 0",
               to, lat, rsp_data, rsp_err, en);
    end
    ack_rsp();
  endtask

  task automatic test_timeout();
    int lat, en;
    bit to;
    // accept at N, RUN from N+1, timeout response 64 cycles later at N+65
    mode = 1;
    send_req(4'd12, 4'd8);
    wait_rsp(lat, en, to);
    checks++;
    if (to || lat != 65 || en != 64 || rsp_data !== 4'd0 || rsp_err !== 1'b1) begin
      failures++;
      $display("FAIL timeout: got to=%b lat=%0d en=%0d data=%0d err=%b, want 0 65 64 0 1",
               to, lat, en, rsp_data, rsp_err);
    end
    checks++;
    if (gcd_reset !== 1'b1 || gcd_enable !== 1'b0) begin
      failures++;
      $display("FAIL timeout_park: got grst=%b gen=%b, want 1 0", gcd_reset, gcd_enable);
    end
    ack_rsp();
    mode = 2;
    send_req(4'd12, 4'd8);
    wait_rsp(lat, en, to);
    checks++;
    if (to || lat != 65 || rsp_data !== 4'd5 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL late_done: got to=%b lat=%0d data=%0d err=%b, want 0 65 5 0",
               to, lat, rsp_data, rsp_err);
    end
    ack_rsp();
    mode = 0;
    checks++;
    if (job_count !== 8'd7) begin
      failures++;
      $display("FAIL count_7: got %0d, want 7", job_count);
    end
  endtask

  task automatic test_backpressure();
    int lat, en;
    bit to;
    send_req(4'd12, 4'd8);
    wait_rsp(lat, en, to);
    req_valid = 1'b1;
    req_x     = 4'd3;
    req_y     = 4'd5;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (to || rsp_valid !== 1'b1 || rsp_data !== 4'd4 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d: got vld=%b data=%0d err=%b rdy=%b, want 1 4 0 0",
                 i, rsp_valid, rsp_data, rsp_err, req_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    ack_rsp();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || job_count !== 8'd8 || gcd_x_i !== 4'd12) begin
      failures++;
      $display("FAIL release: got vld=%b rdy=%b cnt=%0d x=%0d, want 0 1 8 12",
               rsp_valid, req_ready, job_count, gcd_x_i);
    end
  endtask

  task automatic test_midjob_reset();
    int lat, en;
    bit to;
    mode = 1;
    send_req(4'd12, 4'd8);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    mode  = 0;
    checks++;
    if (rsp_valid !== 1'b0 || job_count !== 8'd0 || gcd_enable !== 1'b0 || req_ready !== 1'b1 || gcd_reset !== 1'b1) begin
      failures++;
      $display("FAIL midjob_reset: got vld=%b cnt=%0d gen=%b rdy=%b grst=%b, want 0 0 0 1 1",
               rsp_valid, job_count, gcd_enable, req_ready, gcd_reset);
    end
    send_req(4'd6, 4'd4);
    wait_rsp(lat, en, to);
    checks++;
    if (to || rsp_data !== 4'd2 || rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL gcd_6_4: got to=%b data=%0d err=%b, want 0 2 0", to, rsp_data, rsp_err);
    end
    ack_rsp();
  endtask

  task automatic test_back_to_back();
    int lat, en;
    bit to;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 256; i++) begin
      send_req(4'd3, 4'd6);
      wait_rsp(lat, en, to);
      checks++;
      if (to || rsp_data !== 4'd3 || rsp_err !== 1'b0) begin
        failures++;
        if (bad < 4) $display("FAIL b2b_job%0d: got to=%b data=%0d err=%b, want 0 3 0", i, to, rsp_data, rsp_err);
        bad++;
      end
      ack_rsp();
      if (i == 254) begin
        checks++;
        if (job_count !== 8'd255) begin
          failures++;
          $display("FAIL count_255: got %0d, want 255", job_count);
        end
      end
    end
    checks++;
    if (job_count !== 8'd0) begin
      failures++;
      $display("FAIL count_wrap: got %0d, want 0", job_count);
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_x     = 4'd0;
    req_y     = 4'd0;
    rsp_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_gcd_basic();
    test_gcd_more();
    test_bypass();
    test_timeout();
    test_backpressure();
    test_midjob_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
